// File: rtl/health_tracker.sv
// health_tracker: per-fighter damage/health stage.
// Samples the hitbox contact level once per frame (rising edge of frame_clk),
// removes one health point per hit, enforces an invulnerability window after
// non-lethal hits, and draws the segmented health bar for the color mapper.
// Optional build macro: HEALTH_REGEN_EN adds slow health regeneration in ALIVE.
module health_tracker #(
    parameter int MAX_HEALTH = 5,
    parameter int IFRAMES    = 30,
    parameter int BAR_SEG_W  = 16,
    parameter int BAR_H      = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       contact,
    input  logic [9:0] Health_Pos_X,
    input  logic [9:0] Health_Pos_Y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [3:0] health,
    output logic       is_dead,
    output logic       hit_flash,
    output logic       is_health,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [3:0] MAX_H    = 4'(MAX_HEALTH);
    localparam logic [7:0] IFC_LOAD = 8'(IFRAMES - 1);

    state_t     state, state_n;
    logic [3:0] health_n;
    logic [7:0] ifc, ifc_n;
    logic       frame_clk_d;
    logic       tick;
`ifdef HEALTH_REGEN_EN
    logic [7:0] regen, regen_n;
`endif

    // One-cycle strobe on each rising edge of the frame strobe.
    assign tick      = frame_clk & ~frame_clk_d;
    assign dbg_state = state;

    // Next-state logic: every state change is gated by the frame tick.
    always_comb begin
        state_n  = state;
        health_n = health;
        ifc_n    = ifc;
`ifdef HEALTH_REGEN_EN
        regen_n  = regen;
`endif
        if (tick) begin
            unique case (state)
                ALIVE: begin
                    if (contact) begin
                        if (health <= 4'd1) begin
                            health_n = 4'd0;
                            state_n  = DEAD;
                        end else begin
                            health_n = health - 4'd1;
                            state_n  = INVULN;
                            ifc_n    = IFC_LOAD;
                        end
`ifdef HEALTH_REGEN_EN
                        regen_n = 8'd0;
`endif
                    end else begin
`ifdef HEALTH_REGEN_EN
                        // Regen pays out a point when the counter wraps.
                        regen_n = regen + 8'd1;
                        if (regen == 8'hFF && health < MAX_H)
                            health_n = health + 4'd1;
`endif
                    end
                end
                INVULN: begin
                    // Contact is ignored for the whole window.
                    if (ifc == 8'd0)
                        state_n = ALIVE;
                    else
                        ifc_n = ifc - 8'd1;
`ifdef HEALTH_REGEN_EN
                    regen_n = 8'd0;
`endif
                end
                DEAD: begin
`ifdef HEALTH_REGEN_EN
                    regen_n = 8'd0;
`endif
                end
                default: state_n = ALIVE;
            endcase
        end
    end

    // State and registered outputs; reset pre-loads frame_clk_d so a high
    // frame_clk at release does not produce a spurious tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_d <= 1'b1;
            state       <= ALIVE;
            health      <= MAX_H;
            ifc         <= 8'd0;
            is_dead     <= 1'b0;
            hit_flash   <= 1'b0;
`ifdef HEALTH_REGEN_EN
            regen       <= 8'd0;
`endif
        end else begin
            frame_clk_d <= frame_clk;
            state       <= state_n;
            health      <= health_n;
            ifc         <= ifc_n;
            is_dead     <= (state_n == DEAD);
            hit_flash   <= (state_n == INVULN) & ifc_n[2];
`ifdef HEALTH_REGEN_EN
            regen       <= regen_n;
`endif
        end
    end

    logic [9:0] dx, dy;
    assign dx = DrawX - Health_Pos_X;
    assign dy = DrawY - Health_Pos_Y;

    // Bar pixel: inside the bar box, within the lit length, and not in the
    // 2-pixel gap at the right end of each segment.
    always_comb begin
        is_health = (DrawX >= Health_Pos_X) &&
                    (DrawY >= Health_Pos_Y) &&
                    (int'(dy) < BAR_H) &&
                    (int'(dx) < int'(health) * BAR_SEG_W) &&
                    ((int'(dx) % BAR_SEG_W) < BAR_SEG_W - 2);
    end

endmodule
